// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, shift types,
// status bit positions, the EXE/MEM register layout and small datapath helpers.
package exe_stage_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam int ST_N = 3;
   localparam int ST_Z = 2;
   localparam int ST_C = 1;
   localparam int ST_V = 0;

   localparam logic [1:0] FWD_IDEXE = 2'b00;
   localparam logic [1:0] FWD_MEM   = 2'b01;
   localparam logic [1:0] FWD_WB    = 2'b10;

   typedef struct packed {
      logic        wb_en;
      logic        mem_read;
      logic        mem_write;
      logic [31:0] alu_result;
      logic [31:0] store_val;
      logic [3:0]  dest;
   } exe_mem_t;

   // Rotate right; doubling the word makes amount 0 a plain pass-through.
   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
      logic [63:0] dbl;
      dbl = {v, v} >> amt;
      return dbl[31:0];
   endfunction

   function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] id_val,
                                           input logic [31:0] mem_val, input logic [31:0] wb_val);
      logic [31:0] r;
      case (sel)
         FWD_MEM: r = mem_val;
         FWD_WB:  r = wb_val;
         default: r = id_val;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Second-operand (Val2) generator: rotated immediate, memory offset or
// shifted register value. Purely combinational.
module val2_generator
   import exe_stage_pkg::*;
(
   input  logic [31:0] reg2_i,
   input  logic [11:0] shift_operand_i,
   input  logic        immediate_i,
   input  logic        mem_access_i,
   output logic [31:0] val2_o
);

   logic [4:0] amt_s;
   logic [1:0] sh_type_s;

   assign amt_s     = shift_operand_i[11:7];
   assign sh_type_s = shift_operand_i[6:5];

   // Select the operand source and apply the requested shift or rotate.
   always_comb begin
      val2_o = 32'd0;
      if (immediate_i) begin
         val2_o = ror32({24'd0, shift_operand_i[7:0]}, {shift_operand_i[11:8], 1'b0});
      end else if (mem_access_i) begin
         val2_o = {20'd0, shift_operand_i};
      end else begin
         case (sh_type_s)
            SH_LSL:  val2_o = reg2_i << amt_s;
            SH_LSR:  val2_o = reg2_i >> amt_s;
            SH_ASR:  val2_o = $signed(reg2_i) >>> amt_s;
            SH_ROR:  val2_o = ror32(reg2_i, amt_s);
            default: val2_o = reg2_i;
         endcase
      end
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2, ALU, NZCV status register and the EXE/MEM register.
// Optional operand forwarding is enabled by defining FORWARDING_EN.
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             freeze,
   input  logic             writeBackEn,
   input  logic             memRead,
   input  logic             memWrite,
   input  logic             s,
   input  logic             branch,
   input  logic             immediate,
   input  logic [3:0]       executeCommand,
   input  logic [WIDTH-1:0] PC,
   input  logic [WIDTH-1:0] reg1Val,
   input  logic [WIDTH-1:0] reg2Val,
   input  logic [11:0]      shiftOperand,
   input  logic [23:0]      signedImmediate,
   input  logic [3:0]       destination,
   input  logic             C,
`ifdef FORWARDING_EN
   input  logic [1:0]       sel1,
   input  logic [1:0]       sel2,
   input  logic [WIDTH-1:0] memFwdVal,
   input  logic [WIDTH-1:0] wbFwdVal,
`endif
   output logic             branchTaken,
   output logic [WIDTH-1:0] branchAddress,
   output logic [3:0]       status,
   output logic             wbEnOut,
   output logic             memReadOut,
   output logic             memWriteOut,
   output logic [WIDTH-1:0] aluResult,
   output logic [WIDTH-1:0] storeVal,
   output logic [3:0]       destOut
);

   logic [31:0] op1_s;
   logic [31:0] op2_s;
   logic [31:0] val2_s;
   logic [31:0] b_add_s;
   logic        cin_s;
   logic [32:0] sum_s;
   logic        ovf_s;
   logic [31:0] alu_res_s;
   logic        upd_nz_s;
   logic        upd_cv_s;
   logic [3:0]  flags_s;
   logic [3:0]  status_q;
   exe_mem_t    exe_mem_d;
   exe_mem_t    exe_mem_q;

`ifdef FORWARDING_EN
   assign op1_s = fwd_mux(sel1, reg1Val, memFwdVal, wbFwdVal);
   assign op2_s = fwd_mux(sel2, reg2Val, memFwdVal, wbFwdVal);
`else
   assign op1_s = reg1Val;
   assign op2_s = reg2Val;
`endif

   val2_generator u_val2 (
      .reg2_i          (op2_s),
      .shift_operand_i (shiftOperand),
      .immediate_i     (immediate),
      .mem_access_i    (memRead | memWrite),
      .val2_o          (val2_s)
   );

   assign branchTaken   = branch;
   assign branchAddress = PC + {{6{signedImmediate[23]}}, signedImmediate, 2'b00};

   // Subtract forms add the inverted operand so carry-out reads as NOT borrow.
   always_comb begin
      b_add_s = val2_s;
      cin_s   = 1'b0;
      case (executeCommand)
         CMD_ADC: cin_s = C;
         CMD_SUB: begin b_add_s = ~val2_s; cin_s = 1'b1; end
         CMD_SBC: begin b_add_s = ~val2_s; cin_s = C;    end
         default: cin_s = 1'b0;
      endcase
   end

   assign sum_s = {1'b0, op1_s} + {1'b0, b_add_s} + {32'd0, cin_s};
   assign ovf_s = (op1_s[31] == b_add_s[31]) && (sum_s[31] != op1_s[31]);

   // ALU result and which flag groups the opcode is allowed to update.
   always_comb begin
      alu_res_s = 32'd0;
      upd_nz_s  = 1'b0;
      upd_cv_s  = 1'b0;
      case (executeCommand)
         CMD_MOV: begin alu_res_s = val2_s;          upd_nz_s = 1'b1; end
         CMD_MVN: begin alu_res_s = ~val2_s;         upd_nz_s = 1'b1; end
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
            alu_res_s = sum_s[31:0];
            upd_nz_s  = 1'b1;
            upd_cv_s  = 1'b1;
         end
         CMD_AND: begin alu_res_s = op1_s & val2_s;  upd_nz_s = 1'b1; end
         CMD_ORR: begin alu_res_s = op1_s | val2_s;  upd_nz_s = 1'b1; end
         CMD_EOR: begin alu_res_s = op1_s ^ val2_s;  upd_nz_s = 1'b1; end
         default: alu_res_s = 32'd0;
      endcase
   end

   // Next flag value; groups not touched by the opcode keep their stored value.
   always_comb begin
      flags_s       = status_q;
      flags_s[ST_N] = upd_nz_s ? alu_res_s[31]          : status_q[ST_N];
      flags_s[ST_Z] = upd_nz_s ? (alu_res_s == 32'd0)   : status_q[ST_Z];
      flags_s[ST_C] = upd_cv_s ? sum_s[32]              : status_q[ST_C];
      flags_s[ST_V] = upd_cv_s ? ovf_s                  : status_q[ST_V];
   end

   // Status register: loads only for flag-setting instructions that are not stalled or squashed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q <= 4'd0;
      end else if (s && !freeze && !flush) begin
         status_q <= flags_s;
      end else begin
         status_q <= status_q;
      end
   end

   // Next EXE/MEM contents: freeze holds, flush inserts a bubble, else load.
   always_comb begin
      exe_mem_d = exe_mem_q;
      if (freeze) begin
         exe_mem_d = exe_mem_q;
      end else if (flush) begin
         exe_mem_d = '0;
      end else begin
         exe_mem_d.wb_en      = writeBackEn;
         exe_mem_d.mem_read   = memRead;
         exe_mem_d.mem_write  = memWrite;
         exe_mem_d.alu_result = alu_res_s;
         exe_mem_d.store_val  = op2_s;
         exe_mem_d.dest       = destination;
      end
   end

   // EXE/MEM pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_mem_q <= '0;
      end else begin
         exe_mem_q <= exe_mem_d;
      end
   end

   assign status      = status_q;
   assign wbEnOut     = exe_mem_q.wb_en;
   assign memReadOut  = exe_mem_q.mem_read;
   assign memWriteOut = exe_mem_q.mem_write;
   assign aluResult   = exe_mem_q.alu_result;
   assign storeVal    = exe_mem_q.store_val;
   assign destOut     = exe_mem_q.dest;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage (default build, no forwarding).
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst, flush, freeze;
   logic        writeBackEn, memRead, memWrite, s, branch, immediate;
   logic [3:0]  executeCommand;
   logic [31:0] PC, reg1Val, reg2Val;
   logic [11:0] shiftOperand;
   logic [23:0] signedImmediate;
   logic [3:0]  destination;
   logic        C;
   logic        branchTaken;
   logic [31:0] branchAddress;
   logic [3:0]  status;
   logic        wbEnOut, memReadOut, memWriteOut;
   logic [31:0] aluResult, storeVal;
   logic [3:0]  destOut;

   int checks_cnt = 0;
   int errors_cnt = 0;

   always #5 clk = ~clk;

   exe_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .writeBackEn(writeBackEn), .memRead(memRead), .memWrite(memWrite),
      .s(s), .branch(branch), .immediate(immediate),
      .executeCommand(executeCommand), .PC(PC),
      .reg1Val(reg1Val), .reg2Val(reg2Val), .shiftOperand(shiftOperand),
      .signedImmediate(signedImmediate), .destination(destination), .C(C),
      .branchTaken(branchTaken), .branchAddress(branchAddress), .status(status),
      .wbEnOut(wbEnOut), .memReadOut(memReadOut), .memWriteOut(memWriteOut),
      .aluResult(aluResult), .storeVal(storeVal), .destOut(destOut)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      flush = 1'b0; freeze = 1'b0; writeBackEn = 1'b0; memRead = 1'b0; memWrite = 1'b0;
      s = 1'b0; branch = 1'b0; immediate = 1'b0; executeCommand = 4'd0;
      PC = 32'd0; reg1Val = 32'd0; reg2Val = 32'd0; shiftOperand = 12'd0;
      signedImmediate = 24'd0; destination = 4'd0; C = 1'b0;
   endtask

   task automatic op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                     input logic [11:0] so, input logic imm, input logic set);
      executeCommand = cmd; reg1Val = a; reg2Val = b;
      shiftOperand = so; immediate = imm; s = set;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #2;
      check("rst_alu", aluResult, 32'd0);
      check("rst_status", {28'd0, status}, 32'd0);
      check("rst_ctl", {29'd0, wbEnOut, memReadOut, memWriteOut}, 32'd0);
      check("rst_store", storeVal, 32'd0);
      check("rst_dest", {28'd0, destOut}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      op(4'b0010, 32'd5, 32'd3, 12'd0, 1'b0, 1'b1); writeBackEn = 1'b1; destination = 4'd3;
      step();
      check("add_res", aluResult, 32'd8);
      check("add_status", {28'd0, status}, 32'd0);
      check("add_wb", {31'd0, wbEnOut}, 32'd1);
      check("add_dest", {28'd0, destOut}, 32'd3);
      check("add_store", storeVal, 32'd3);

      op(4'b0100, 32'd3, 32'd0, 12'h005, 1'b1, 1'b1);
      step();
      check("sub_res", aluResult, 32'hFFFF_FFFE);
      check("sub_status", {28'd0, status}, 32'h8);

      op(4'b0001, 32'd0, 32'd0, 12'h2FF, 1'b1, 1'b0);
      step();
      check("mov_rotimm", aluResult, 32'hF000_000F);
      check("mov_s0_status", {28'd0, status}, 32'h8);

      op(4'b0001, 32'd0, 32'h0000_0001, 12'h200, 1'b0, 1'b0);
      step();
      check("lsl4", aluResult, 32'h0000_0010);
      op(4'b0001, 32'd0, 32'h8000_0000, 12'hFA0, 1'b0, 1'b0);
      step();
      check("lsr31", aluResult, 32'h0000_0001);
      op(4'b0001, 32'd0, 32'h8000_0000, 12'h240, 1'b0, 1'b0);
      step();
      check("asr4", aluResult, 32'hF800_0000);
      op(4'b0001, 32'd0, 32'h0000_0001, 12'h0E0, 1'b0, 1'b0);
      step();
      check("ror1", aluResult, 32'h8000_0000);

      op(4'b0010, 32'h0000_1000, 32'hDEAD_BEEF, 12'hFFF, 1'b0, 1'b0); memRead = 1'b1;
      step();
      check("mem_addr", aluResult, 32'h0000_1FFF);
      check("mem_rd", {31'd0, memReadOut}, 32'd1);
      check("mem_store", storeVal, 32'hDEAD_BEEF);
      memRead = 1'b0;

      op(4'b0010, 32'h7FFF_FFFF, 32'd1, 12'd0, 1'b0, 1'b1);
      step();
      check("add_ovf_res", aluResult, 32'h8000_0000);
      check("add_ovf_status", {28'd0, status}, 32'h9);
      op(4'b0010, 32'hFFFF_FFFF, 32'd1, 12'd0, 1'b0, 1'b1);
      step();
      check("add_cz_status", {28'd0, status}, 32'h6);
      op(4'b1000, 32'h8000_0000, 32'd0, 12'd0, 1'b0, 1'b1);
      step();
      check("eor_res", aluResult, 32'h8000_0000);
      check("eor_keep_cv", {28'd0, status}, 32'hA);
      op(4'b1111, 32'd7, 32'd9, 12'd0, 1'b0, 1'b1);
      step();
      check("undef_res", aluResult, 32'd0);
      check("undef_status", {28'd0, status}, 32'hA);
      op(4'b1001, 32'd0, 32'd0, 12'd0, 1'b0, 1'b0);
      step();
      check("mvn", aluResult, 32'hFFFF_FFFF);
      op(4'b0101, 32'd5, 32'd3, 12'd0, 1'b0, 1'b1); C = 1'b0;
      step();
      check("sbc_res", aluResult, 32'd1);
      check("sbc_status", {28'd0, status}, 32'h2);

      branch = 1'b1; PC = 32'h0000_0100; signedImmediate = 24'hFFFFFE;
      #1;
      check("br_taken", {31'd0, branchTaken}, 32'd1);
      check("br_addr", branchAddress, 32'h0000_00F8);
      PC = 32'hFFFF_FFFC; signedImmediate = 24'h000001;
      #1;
      check("br_wrap", branchAddress, 32'h0000_0000);
      branch = 1'b0;
      #1;
      check("br_not", {31'd0, branchTaken}, 32'd0);

      op(4'b0010, 32'd5, 32'd3, 12'd0, 1'b0, 1'b1); writeBackEn = 1'b1;
      step();
      check("pre_frz_res", aluResult, 32'd8);
      freeze = 1'b1;
      op(4'b0100, 32'd3, 32'd0, 12'h005, 1'b1, 1'b1);
      step();
      step();
      check("frz_res", aluResult, 32'd8);
      check("frz_wb", {31'd0, wbEnOut}, 32'd1);
      check("frz_status", {28'd0, status}, 32'd0);
      freeze = 1'b0; flush = 1'b1;
      step();
      check("flush_wb", {31'd0, wbEnOut}, 32'd0);
      check("flush_res", aluResult, 32'd0);
      check("flush_status", {28'd0, status}, 32'd0);
      flush = 1'b0;

      step();
      check("pre_rst_status", {28'd0, status}, 32'h8);
      #2;
      rst = 1'b1;
      #1;
      check("arst_res", aluResult, 32'd0);
      check("arst_status", {28'd0, status}, 32'd0);
      check("arst_wb", {31'd0, wbEnOut}, 32'd0);
      rst = 1'b0;
      op(4'b0011, 32'd1, 32'd1, 12'd0, 1'b0, 1'b0); C = 1'b1;
      step();
      check("adc_res", aluResult, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage. Consumes the ID/EXE pipeline register outputs and computes the shifter operand (Val2), the ALU result, the branch target and the status flags.
- Holds the architectural status register (NZCV) and drives it back to decode.
- Registers its results into an integrated EXE/MEM pipeline register, so results appear one cycle after inputs.

Parameters:
- WIDTH, 32, datapath width. Only 32 is legal; the parameter exists for readability.

Ports:
- clk  input  1  pipeline clock, posedge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  clear EXE/MEM register (bubble) next edge
- freeze  input  1  hold EXE/MEM register and status register
- writeBackEn, memRead, memWrite, s, branch, immediate  input  1 each  from ID/EXE
- executeCommand  input  4  ALU opcode
- PC  input  32  PC+4 of instruction
- reg1Val, reg2Val  input  32  operand values
- shiftOperand  input  12  shifter field
- signedImmediate  input  24  branch offset
- destination  input  4  Rd
- C  input  1  carry used by ADC/SBC
- branchTaken  output  1  combinational, equal to branch
- branchAddress  output  32  combinational, PC + (sext(signedImmediate) << 2)
- status  output  4  registered {N,Z,C,V} to decode
- wbEnOut, memReadOut, memWriteOut  output  1 each  registered
- aluResult  output  32  registered
- storeVal  output  32  registered; reg2Val, or its forwarded value
- destOut  output  4  registered

Behaviour:
- Reset (async, rst=1): status=0; wbEnOut=memReadOut=memWriteOut=0; aluResult=0; storeVal=0; destOut=0.
- Val2 generation:
  - immediate=1: zero-extended shiftOperand[7:0] rotated right by 2*shiftOperand[11:8].
  - Otherwise, memRead|memWrite: zero-extended shiftOperand[11:0].
  - Otherwise: reg2Val shifted by shiftOperand[11:7] with type shiftOperand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 passes reg2Val unchanged.
- ALU (A = reg1Val, B = Val2). For memory ops, decode supplies executeCommand=0010.
  - 0001 MOV: B
  - 1001 MVN: ~B
  - 0010 ADD: A+B
  - 0011 ADC: A+B+C
  - 0100 SUB/CMP: A-B
  - 0101 SBC: A-B-!C
  - 0110 AND/TST: A&B
  - 0111 ORR: A|B
  - 1000 EOR: A^B
  - Any other code: result 0, flags unchanged.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C = bit 32 of the 33-bit sum. For subtract forms, C = NOT borrow. V = signed overflow.
  - Logic and move ops leave C and V unchanged.
- Status register update: loads at posedge only when s=1, freeze=0 and flush=0; otherwise it holds.
- EXE/MEM register, priority rst > freeze > flush > load:
  - freeze=1: all outputs hold, including during flush.
  - flush=1 (freeze=0): all registered outputs go to 0.
  - Otherwise: load.
- Latency: aluResult is valid on the cycle after the inputs are presented. branchTaken/branchAddress have 0 latency for IF redirect and flush generation.
- Boundary conditions:
  - A branch instruction itself writes nothing: decode guarantees writeBackEn=0, memRead=0, memWrite=0.
  - PC+offset wraps modulo 2^32.
  - rst asserted mid-operation clears immediately, without waiting for a clock edge.

Optional Feature:
- FORWARDING_EN defined: adds ports
  - sel1, sel2 input 2 (00 ID/EXE value, 01 MEM aluResult, 10 WB value)
  - memFwdVal input 32
  - wbFwdVal input 32
- The forwarded operands replace reg1Val and reg2Val. This applies to Val2 shifting and to storeVal.
- Select 11 behaves as 00.
- Undefined: ports are absent and raw reg1Val/reg2Val are used.

Decomposition:
- Shared package: executeCommand opcode constants, shift-type constants, status bit indices.
- Natural sub-module: val2_generator (combinational shifter/rotator), instantiated once.
- ALU, status register and EXE/MEM register stay inline.

Test Plan:
- ADD, no imm: reg1Val=5, reg2Val=3, shiftOperand=0, s=1 -> next cycle aluResult=8, status=0000.
- SUB, s=1: reg1Val=3, Val2=imm 5 -> aluResult=0xFFFFFFFE, status N=1 Z=0 C=0 V=0.
- Immediate rotate: shiftOperand=12'h2FF (rotate 4) -> Val2=0xF000000F, MOV result 0xF000000F.
- Branch: PC=0x100, signedImmediate=24'hFFFFFE, branch=1 -> branchAddress=0xF8 same cycle, branchTaken=1.
- Freeze/flush: freeze=1 for 2 cycles -> outputs and status held; then flush=1 -> wbEnOut=0, aluResult=0; status unchanged despite s=1.
- Async reset mid-stream: rst pulse between edges -> all outputs 0 immediately; ADC with C=1 after reset: 1+1+1 -> 3.
